demux13x64_reg: RTL and testbench
=================================

Name: demux13x64_reg

Overview:
- Registered 1-to-3 demultiplexer, the inverse of the 3:1 operand-select mux.
- Accepts one 64-bit word per cycle on a valid/ready input port and steers it to output port A, B or C according to a 2-bit select.
- Each output holds the word in its own one-entry register until the downstream stage accepts it.
- Used to fan a shared result bus back out to per-unit operand registers in the arithmetic datapath.

Parameters:
- WIDTH, 64, data width of every port.
- CNTW, 16, width of the dropped-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- datain  in  WIDTH  input word.
- s  in  2  destination select, sampled with datain: 00 → A, 01 → B, 10 → C, 11 → illegal.
- in_valid  in  1  datain and s are valid this cycle.
- in_ready  out  1  block can accept this cycle (combinational).
- a_data / b_data / c_data  out  WIDTH  registered output word, one per port.
- a_valid / b_valid / c_valid  out  1  output register holds a word.
- a_ready / b_ready / c_ready  in  1  downstream accepts the word.
- err  out  1  sticky flag; set when a word with s=11 is accepted.
- drop_cnt  out  CNTW  number of words discarded because s=11.

Behaviour:
- Reset: all x_valid=0, all x_data=0, err=0, drop_cnt=0. Reset wins over any handshake in the same cycle. A word held at reset is lost.
- Transfers: input transfer when in_valid && in_ready; output transfer on port x when x_valid && x_ready.
- Slot state per port: EMPTY (valid=0) or FULL (valid=1).
  - EMPTY → FULL on an input transfer addressed to x.
  - FULL → EMPTY on an output transfer with no new word addressed to x.
  - FULL → FULL (data replaced) on simultaneous output and input transfers addressed to x. This gives full throughput.
- in_ready by select:
  - s=00: !a_valid || a_ready.
  - s=01: !b_valid || b_ready.
  - s=10: !c_valid || c_ready.
  - s=11: 1.
- in_ready depends only on s and the addressed port. A busy port never stalls words bound for other ports.
- Latency: a word accepted in cycle N appears on x_data with x_valid=1 in cycle N+1.
- Data stability: x_data changes only on an input transfer into that slot. It is stable while x_valid && !x_ready.
- Illegal select (s=11): the word is accepted and discarded, no slot changes, err←1, drop_cnt←drop_cnt+1.
  - drop_cnt saturates at all-ones and does not wrap.
  - err clears only on reset.
- in_valid=0: s and datain are ignored, and no state changes except output drains.
- Routing: each accepted word goes to exactly one port, and no word is ever duplicated.
- Ordering: order is preserved per port. There is no ordering guarantee across ports.
- Protocol rule, checked as an assertion: upstream must hold datain and s stable while in_valid && !in_ready.

Decomposition:
- Shared package (arith_pkg): select constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_ILL=2'b11, plus the default WIDTH. The 3:1 mux and this block must use the same encoding.
- Sub-module demux_slot (WIDTH):
  - one-entry register with load/valid/ready and the "ready = !valid || out_ready" term;
  - instantiated three times.
- The top level adds select decode, the in_ready mux, and the err/drop_cnt logic.

Test Plan:
- Reset then one word each: datain=64'h1111 s=00, 64'h2222 s=01, 64'h3333 s=10 on consecutive cycles, all readys high. Expect a_data=1111, b_data=2222, c_data=3333, each valid exactly one cycle after its input cycle, and in_ready constantly 1.
- Backpressure: a_ready=0, send 64'hAAAA and then 64'hBBBB to A. Expect:
  - first word held with a_valid=1 and a_data stable;
  - in_ready=0 while s=00;
  - raising a_ready delivers AAAA then BBBB in order with no bubble.
- Independence: a_ready=0 and A full, then send 64'hC0DE to C. Expect in_ready=1, c_data=C0DE next cycle, and A unchanged.
- Illegal select: three words with s=11 and in_valid=1. Expect in_ready=1, no x_valid asserted, err=1 after the first, and drop_cnt=3. After reset, err=0 and drop_cnt=0.
- Saturation: CNTW=2 build, five s=11 words. Expect drop_cnt=3 (not 1).
- Reset mid-operation: A and B full with readys low, assert reset for one cycle concurrent with an incoming s=10 word. Expect all valids=0, all data=0, and the C word not captured.

Source files
------------

// File: rtl/arith_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arith_pkg: select encoding and widths shared by 3:1 mux/demux    |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
package arith_pkg;

  localparam int DEF_WIDTH = 64;

  // The operand mux and the demux must agree on this encoding.
  typedef enum logic [1:0] {
    SEL_A   = 2'b00,
    SEL_B   = 2'b01,
    SEL_C   = 2'b10,
    SEL_ILL = 2'b11
  } sel_e;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux_slot: one-entry output register with valid/ready handshake|
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module demux_slot
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  slot_state_e      r_state;
  slot_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A load while full replaces the word being drained, so the slot stays full.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_next = SLOT_FULL;
      SLOT_FULL:  if (!i_load && i_out_ready) w_state_next = SLOT_EMPTY;
      default:    w_state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid    = (r_state == SLOT_FULL);
  assign o_data     = r_data;
  assign o_in_ready = !o_valid || i_out_ready;

endmodule
`default_nettype wire

// File: rtl/demux13x64_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux13x64_reg: registered 1-to-3 demux with illegal-select count|
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module demux13x64_reg
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] datain,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] c_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  output logic             err,
  output logic [CNTW-1:0]  drop_cnt
);

  logic [2:0]       w_out_ready;
  logic [2:0]       w_out_valid;
  logic [2:0]       w_slot_ready;
  logic [2:0]       w_load;
  logic [WIDTH-1:0] w_out_data [3];
  logic             w_xfer;
  logic             w_drop;
  logic             r_err;
  logic [CNTW-1:0]  r_drop_cnt;

  assign w_out_ready = {c_ready, b_ready, a_ready};

  // Ready depends only on the addressed slot, so a stalled port never blocks the others.
  always_comb begin
    in_ready = 1'b1;
    case (s)
      SEL_A:   in_ready = w_slot_ready[0];
      SEL_B:   in_ready = w_slot_ready[1];
      SEL_C:   in_ready = w_slot_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_xfer = in_valid && in_ready;
  assign w_drop = w_xfer && (s == SEL_ILL);

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    localparam logic [1:0] c_sel = 2'(gi);

    assign w_load[gi] = w_xfer && (s == c_sel);

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load[gi]),
      .i_data     (datain),
      .i_out_ready(w_out_ready[gi]),
      .o_in_ready (w_slot_ready[gi]),
      .o_valid    (w_out_valid[gi]),
      .o_data     (w_out_data[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_err <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNTW'(1);
    end
  end

  assign a_data   = w_out_data[0];
  assign b_data   = w_out_data[1];
  assign c_data   = w_out_data[2];
  assign a_valid  = w_out_valid[0];
  assign b_valid  = w_out_valid[1];
  assign c_valid  = w_out_valid[2];
  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> ($stable(datain) && $stable(s)));

endmodule
`default_nettype wire

// File: tb/tb_demux13x64_reg.sv
`default_nettype none
// Randomised and directed check of demux13x64_reg against a queue-based model.
module tb_demux13x64_reg;

  logic        clk;
  logic        reset;
  logic [63:0] datain;
  logic [1:0]  s;
  logic        in_valid;
  logic        a_ready, b_ready, c_ready;
  logic        in_ready, a_valid, b_valid, c_valid, err;
  logic [63:0] a_data, b_data, c_data;
  logic [15:0] drop_cnt;

  logic        t_in_ready, t_a_valid, t_b_valid, t_c_valid, t_err;
  logic [63:0] t_a_data, t_b_data, t_c_data;
  logic [1:0]  t_drop_cnt;

  demux13x64_reg u_dut (
    .clk(clk), .reset(reset), .datain(datain), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .b_data(b_data), .c_data(c_data),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
    .err(err), .drop_cnt(drop_cnt)
  );

  demux13x64_reg #(.WIDTH(64), .CNTW(2)) u_dut_sat (
    .clk(clk), .reset(reset), .datain(datain), .s(s), .in_valid(in_valid),
    .in_ready(t_in_ready), .a_data(t_a_data), .b_data(t_b_data), .c_data(t_c_data),
    .a_valid(t_a_valid), .b_valid(t_b_valid), .c_valid(t_c_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
    .err(t_err), .drop_cnt(t_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] q [3][$];
  logic [63:0] last [3];
  int          m_cnt;
  logic        m_err;
  logic        m_init = 1'b0;
  logic        hold = 1'b0;
  string       pn [3] = '{"a", "b", "c"};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] sel,
                       input logic [63:0] d, input logic [2:0] rdy);
    logic        exp_rdy;
    logic        ov [3];
    logic [63:0] od [3];
    reset = r; in_valid = v; s = sel; datain = d;
    {c_ready, b_ready, a_ready} = rdy;
    #1;
    exp_rdy = (sel == 2'd3) || (q[sel].size() == 0) || rdy[sel];
    ov = '{a_valid, b_valid, c_valid};
    od = '{a_data, b_data, c_data};
    if (m_init) begin
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      for (int p = 0; p < 3; p++) begin
        check_eq({pn[p], "_valid"}, {63'd0, ov[p]}, {63'd0, q[p].size() != 0});
        check_eq({pn[p], "_data"}, od[p], last[p]);
      end
      check_eq("err", {63'd0, err}, {63'd0, m_err});
      check_eq("drop_cnt", {48'd0, drop_cnt}, 64'((m_cnt > 65535) ? 65535 : m_cnt));
      check_eq("drop_cnt_sat", {62'd0, t_drop_cnt}, 64'((m_cnt > 3) ? 3 : m_cnt));
    end
    hold = v && !exp_rdy && !r;
    @(posedge clk);
    if (r) begin
      for (int p = 0; p < 3; p++) begin
        q[p].delete();
        last[p] = 64'd0;
      end
      m_cnt = 0; m_err = 1'b0; m_init = 1'b1;
    end else begin
      for (int p = 0; p < 3; p++)
        if (q[p].size() != 0 && rdy[p]) void'(q[p].pop_front());
      if (v && exp_rdy) begin
        if (sel == 2'd3) begin
          m_err = 1'b1;
          m_cnt++;
        end else begin
          q[sel].push_back(d);
          last[sel] = d;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        rv, vv;
    logic [1:0]  sv;
    logic [63:0] dv;
    logic [2:0]  rd;
    reset = 1'b1; in_valid = 1'b0; s = 2'd0; datain = '0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    @(negedge clk);
    drive(1, 0, 2'd0, 64'd0, 3'b111);
    drive(1, 0, 2'd0, 64'd0, 3'b111);
    // One word per port, all readys high
    drive(0, 1, 2'd0, 64'h1111, 3'b111);
    drive(0, 1, 2'd1, 64'h2222, 3'b111);
    drive(0, 1, 2'd2, 64'h3333, 3'b111);
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    // Backpressure on A, then release
    drive(0, 1, 2'd0, 64'hAAAA, 3'b110);
    drive(0, 1, 2'd0, 64'hBBBB, 3'b110);
    drive(0, 1, 2'd0, 64'hBBBB, 3'b110);
    drive(0, 1, 2'd0, 64'hBBBB, 3'b111);
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    // A full and stalled while C proceeds
    drive(0, 1, 2'd0, 64'h5A5A, 3'b110);
    drive(0, 1, 2'd2, 64'hC0DE, 3'b110);
    drive(0, 0, 2'd0, 64'h0, 3'b110);
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    // Illegal selects
    for (int i = 0; i < 3; i++) drive(0, 1, 2'd3, 64'hDEAD + 64'(i), 3'b111);
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    drive(1, 0, 2'd0, 64'h0, 3'b111);
    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) drive(0, 1, 2'd3, 64'hBEEF, 3'b111);
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    // Reset mid-operation with an incoming C word
    drive(0, 1, 2'd0, 64'h0A0A, 3'b000);
    drive(0, 1, 2'd1, 64'h0B0B, 3'b000);
    drive(1, 1, 2'd2, 64'h0C0C, 3'b000);
    drive(0, 0, 2'd0, 64'h0, 3'b000);
    // Random traffic, holding stalled words stable
    sv = 2'd0; dv = 64'd0; vv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rv = 1'b0;
      if (!hold) begin
        vv = ($urandom_range(0, 9) < 7);
        sv = 2'($urandom_range(0, 3));
        dv = {$urandom, $urandom};
        rv = ($urandom_range(0, 199) == 0);
      end
      rd = 3'($urandom_range(0, 7));
      drive(rv, hold ? 1'b1 : vv, sv, dv, rd);
    end
    drive(0, 0, 2'd0, 64'h0, 3'b111);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
